timer_cmp_irq: RTL and testbench
================================

// Module: timer_cmp_irq
// PURPOSE
//  Compare/interrupt stage downstream of the free-running 8-bit timer counter.
//  - Consumes the counter value each cycle and raises a level interrupt when it hits a programmed compare value.
//  - Supports one-shot and periodic (auto-reload by PERIOD) modes.
//  - Configured by a small single-cycle register port; interrupt cleared by ack pulse.
// PARAMETERS
//  TW      8     timer/compare width; must equal the upstream counter width
//  AW      2     config address width (4 registers)
// PORTS
//  clk        in   1    single clock, rising edge
//  resetn     in   1    asynchronous, active-low reset
//  timer_val  in   TW   free-running count from upstream timer
//  cfg_we     in   1    register write strobe (1 cycle)
//  cfg_addr   in   AW   register address
//  cfg_wdata  in   TW   write data
//  cfg_rdata  out  TW   read data, combinational on cfg_addr
//  irq_ack    in   1    1-cycle pulse; clears pending interrupt
//  irq        out  1    registered interrupt = pending & CTRL.irq_en
//  fire       out  1    registered 1-cycle pulse per accepted match
// BEHAVIOUR
//  Registers: 0 CTRL {[0]en,[1]periodic,[2]irq_en}; 1 CMP; 2 PERIOD; 3 STATUS {[0]pending,[1]overrun}, write-1-to-clear.
//  Reset (resetn=0, async): CTRL=0, CMP=0, PERIOD=0, STATUS=0, state=IDLE, tv_q=0, irq=0, fire=0.
//  FSM states: IDLE, ARMED, DONE.
//   - IDLE: entered by writing CTRL.en=1 -> ARMED next edge.
//   - ARMED + match: one-shot -> DONE with CTRL.en cleared; periodic -> stays ARMED.
//   - DONE: writing CTRL.en=1 -> ARMED.
//   - Any state: write CTRL.en=0 -> IDLE. Pending is not cleared by this.
//  Match = state==ARMED && timer_val==CMP && timer_val!=tv_q (tv_q = timer_val registered each cycle).
//   - A stalled counter therefore fires once only.
//  On match edge:
//   - fire=1 for exactly 1 cycle.
//   - pending<=1.
//   - If pending was already 1 and no irq_ack in the same cycle, overrun<=1.
//   - Periodic: CMP <= CMP+PERIOD mod 2^TW; wrap is silent.
//   - PERIOD=0 in periodic: CMP unchanged, so next fire is after a full 2^TW wrap.
//  Latency: match sampled at edge N -> irq/fire high after edge N (1 cycle). irq falls 1 cycle after the ack edge.
//  Simultaneous events:
//   - match+irq_ack same cycle: pending stays 1, no overrun.
//   - cfg write to CMP on a match cycle: the software write wins over the periodic reload.
//   - STATUS W1C together with a match: set wins.
//   - W1C and irq_ack both clear pending.
//  cfg writes to reserved CTRL bits are ignored and read back as 0. STATUS[TW-1:2] reads 0.
//  Reset asserted mid-operation: all state returns to reset values immediately; irq drops without waiting for clk.
// STRUCTURE
//  Shared package timer_pkg:
//   - register address constants (TMR_CTRL/CMP/PERIOD/STATUS)
//   - CTRL/STATUS bit indices
//   - FSM state encoding
//   - TW default
//  One natural sub-module: timer_cmp_regs. It holds the register file, W1C logic and rdata mux.
//  The top holds tv_q, the match detect, the FSM and the irq/fire registers.
// TESTING
//  1 Reset: resetn low async mid-cycle with irq=1 -> irq=0 at once; all regs read 0; state IDLE.
//  2 One-shot: CMP=0x10, CTRL=0x5, counter free-running.
//    - Expected: fire pulses once after timer_val 0x10, irq=1, CTRL reads 0x4.
//    - irq_ack -> irq=0 next cycle; no further fires over 512 cycles.
//  3 Periodic: CMP=0xF0, PERIOD=0x20, CTRL=0x7.
//    - Expected: fires at 0xF0, 0x10 (wrap), 0x30, i.e. every 32 cycles.
//    - irq acked after each fire; STATUS.overrun stays 0.
//  4 Overrun: periodic PERIOD=0x08 and never ack.
//    - Expected: second fire sets STATUS=0x3.
//    - Write STATUS=0x2 -> reads 0x1; irq stays 1.
//  5 Simultaneous events:
//    - irq_ack coincident with match -> pending 1, overrun 0.
//    - CMP write on a periodic match cycle -> CMP holds the written value.
//  6 Stalled input: hold timer_val=0x10 (=CMP) for 20 cycles -> exactly one fire pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer compare/interrupt slice: register map,
// CTRL/STATUS bit positions and the compare FSM encoding.
package timer_pkg;

  localparam int unsigned TW_DEF = 8;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_CMP    = 2'd1;
  localparam logic [1:0] TMR_PERIOD = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  localparam int unsigned ST_PENDING = 0;
  localparam int unsigned ST_OVERRUN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/timer_cmp_regs.sv
// Register file for the compare stage: CTRL/CMP/PERIOD/STATUS, W1C status,
// periodic compare reload and the combinational read mux.
module timer_cmp_regs
  import timer_pkg::*;
#(
  parameter int unsigned TW = TW_DEF,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [TW-1:0] cfg_wdata,
  input  logic          match,
  input  logic          irq_ack,
  output logic [TW-1:0] cfg_rdata,
  output logic [TW-1:0] cmp,
  output logic          periodic,
  output logic          pending_d,
  output logic          irq_en_d
);

  logic [2:0]    ctrl_q, ctrl_d;
  logic [TW-1:0] cmp_q, cmp_d;
  logic [TW-1:0] period_q, period_d;
  logic          pending_q;
  logic          overrun_q, overrun_d;
  logic          wr_ctrl, wr_cmp, wr_period, wr_status;

  assign wr_ctrl   = cfg_we && (cfg_addr == AW'(TMR_CTRL));
  assign wr_cmp    = cfg_we && (cfg_addr == AW'(TMR_CMP));
  assign wr_period = cfg_we && (cfg_addr == AW'(TMR_PERIOD));
  assign wr_status = cfg_we && (cfg_addr == AW'(TMR_STATUS));

  assign cmp      = cmp_q;
  assign periodic = ctrl_q[CTRL_PERIODIC];
  assign irq_en_d = ctrl_d[CTRL_IRQ_EN];

  // Software writes beat hardware updates; status sets beat clears.
  always_comb begin
    ctrl_d    = ctrl_q;
    cmp_d     = cmp_q;
    period_d  = period_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (wr_ctrl) begin
      ctrl_d = cfg_wdata[2:0];
    end else if (match && !ctrl_q[CTRL_PERIODIC]) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr_cmp) begin
      cmp_d = cfg_wdata;
    end else if (match && ctrl_q[CTRL_PERIODIC]) begin
      cmp_d = cmp_q + period_q;
    end
    if (wr_period) begin
      period_d = cfg_wdata;
    end
    if (irq_ack || (wr_status && cfg_wdata[ST_PENDING])) begin
      pending_d = 1'b0;
    end
    if (match) begin
      pending_d = 1'b1;
    end
    if (wr_status && cfg_wdata[ST_OVERRUN]) begin
      overrun_d = 1'b0;
    end
    if (match && pending_q && !irq_ack) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q    <= '0;
      cmp_q     <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      AW'(TMR_CTRL):   cfg_rdata[2:0] = ctrl_q;
      AW'(TMR_CMP):    cfg_rdata = cmp_q;
      AW'(TMR_PERIOD): cfg_rdata = period_q;
      default: begin
        cfg_rdata[ST_PENDING] = pending_q;
        cfg_rdata[ST_OVERRUN] = overrun_q;
      end
    endcase
  end

endmodule

// File: rtl/timer_cmp_irq.sv
// Compare/interrupt stage behind the free-running timer: edge-qualified match
// detect, IDLE/ARMED/DONE control FSM and registered irq/fire outputs.
module timer_cmp_irq
  import timer_pkg::*;
#(
  parameter int unsigned TW = TW_DEF,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [TW-1:0] timer_val,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [TW-1:0] cfg_wdata,
  output logic [TW-1:0] cfg_rdata,
  input  logic          irq_ack,
  output logic          irq,
  output logic          fire
);

  tmr_state_e    state_q, state_d;
  logic [TW-1:0] tv_q;
  logic [TW-1:0] cmp;
  logic          periodic;
  logic          pending_d;
  logic          irq_en_d;
  logic          match;
  logic          wr_ctrl;

  timer_cmp_regs #(
    .TW(TW),
    .AW(AW)
  ) u_regs (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .match     (match),
    .irq_ack   (irq_ack),
    .cfg_rdata (cfg_rdata),
    .cmp       (cmp),
    .periodic  (periodic),
    .pending_d (pending_d),
    .irq_en_d  (irq_en_d)
  );

  // Requiring a change from last cycle makes a stalled counter fire only once.
  assign match   = (state_q == ARMED) && (timer_val == cmp) && (timer_val != tv_q);
  assign wr_ctrl = cfg_we && (cfg_addr == AW'(TMR_CTRL));

  always_comb begin
    state_d = state_q;
    if (wr_ctrl) begin
      state_d = cfg_wdata[CTRL_EN] ? ARMED : IDLE;
    end else if (match && !periodic) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tv_q    <= '0;
      fire    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state_q <= state_d;
      tv_q    <= timer_val;
      fire    <= match;
      irq     <= pending_d & irq_en_d;
    end
  end

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed bench for timer_cmp_irq: register vector table plus hand-written
// sequences for one-shot, periodic, overrun, coincident events and stall.
module tb_timer_cmp_irq;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_CMP    = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] timer_val;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       irq_ack;
  logic       irq;
  logic       fire;

  logic       run;
  logic [7:0] sampled;
  int         n_cmp = 0;
  int         n_bad = 0;

  timer_cmp_irq #(
    .TW(8),
    .AW(2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .timer_val (timer_val),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_ack   (irq_ack),
    .irq       (irq),
    .fire      (fire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock; 'sampled' is the timer value the DUT saw at that edge.
  task automatic step();
    @(posedge clk);
    sampled = timer_val;
    #1;
    if (run) timer_val = timer_val + 8'd1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [7:0] e);
    cfg_addr = a;
    #1;
    check(nm, cfg_rdata, e);
  endtask

  int         nf;
  int         extra;
  logic [7:0] fire_tv[3];
  int         fire_cyc[3];

  initial begin
    resetn = 1'b0; timer_val = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; irq_ack = 1'b0; run = 1'b0; sampled = '0;

    vecs[0] = '{A_CMP,    8'hA5, 8'hA5};
    vecs[1] = '{A_PERIOD, 8'h3C, 8'h3C};
    vecs[2] = '{A_CTRL,   8'hFA, 8'h02};
    vecs[3] = '{A_STATUS, 8'hFF, 8'h00};
    vecs[4] = '{A_CTRL,   8'h04, 8'h04};
    vecs[5] = '{A_CMP,    8'h00, 8'h00};
    vecs[6] = '{A_PERIOD, 8'hFF, 8'hFF};

    #12;
    check("rst_irq", irq, 0);
    check("rst_fire", fire, 0);
    rd_chk("rst_ctrl", A_CTRL, 8'h00);
    rd_chk("rst_cmp", A_CMP, 8'h00);
    resetn = 1'b1;
    rd_chk("rst_status", A_STATUS, 8'h00);

    for (int i = 0; i < 7; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // One-shot at 0x10
    wr(A_CMP, 8'h10);
    wr(A_CTRL, 8'h05);
    run = 1'b1;
    nf = 0;
    for (int i = 0; i < 300 && nf == 0; i++) begin
      step();
      if (fire) nf = 1;
    end
    check("os_fire_seen", nf, 1);
    check("os_fire_tv", sampled, 8'h10);
    check("os_irq", irq, 1);
    rd_chk("os_ctrl", A_CTRL, 8'h04);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("os_irq_ack", irq, 0);
    extra = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (fire) extra++;
    end
    check("os_no_refire", extra, 0);

    // Periodic with wrap: 0xF0, 0x10, 0x30
    run = 1'b0;
    timer_val = 8'hE0;
    wr(A_CMP, 8'hF0);
    wr(A_PERIOD, 8'h20);
    wr(A_CTRL, 8'h07);
    run = 1'b1;
    nf = 0;
    for (int i = 0; i < 200 && nf < 3; i++) begin
      step();
      irq_ack = 1'b0;
      if (fire) begin
        fire_tv[nf]  = sampled;
        fire_cyc[nf] = i;
        nf++;
        irq_ack = 1'b1;
      end
    end
    if (irq_ack) step();
    irq_ack = 1'b0;
    check("per_count", nf, 3);
    check("per_tv0", fire_tv[0], 8'hF0);
    check("per_tv1", fire_tv[1], 8'h10);
    check("per_tv2", fire_tv[2], 8'h30);
    check("per_gap01", fire_cyc[1] - fire_cyc[0], 32);
    check("per_gap12", fire_cyc[2] - fire_cyc[1], 32);
    rd_chk("per_status", A_STATUS, 8'h00);

    // Overrun without ack
    run = 1'b0;
    timer_val = 8'h40;
    wr(A_PERIOD, 8'h08);
    wr(A_CMP, 8'h44);
    run = 1'b1;
    nf = 0;
    for (int i = 0; i < 50 && nf < 2; i++) begin
      step();
      if (fire) begin
        nf++;
        if (nf == 1) begin
          check("ovr_tv0", sampled, 8'h44);
          rd_chk("ovr_status1", A_STATUS, 8'h01);
        end else begin
          check("ovr_tv1", sampled, 8'h4C);
          rd_chk("ovr_status2", A_STATUS, 8'h03);
          check("ovr_irq", irq, 1);
        end
      end
    end
    check("ovr_count", nf, 2);
    run = 1'b0;
    wr(A_STATUS, 8'h02);
    rd_chk("ovr_w1c", A_STATUS, 8'h01);
    check("ovr_w1c_irq", irq, 1);

    // Asynchronous reset mid-cycle with irq high
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_irq", irq, 0);
    rd_chk("arst_ctrl", A_CTRL, 8'h00);
    rd_chk("arst_cmp", A_CMP, 8'h00);
    rd_chk("arst_period", A_PERIOD, 8'h00);
    rd_chk("arst_status", A_STATUS, 8'h00);
    resetn = 1'b1;
    timer_val = 8'h00;
    run = 1'b1;
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (fire) extra++;
    end
    check("arst_idle_nofire", extra, 0);

    // Coincident ack+match, then CMP write on a periodic match
    run = 1'b0;
    timer_val = 8'h00;
    wr(A_PERIOD, 8'h04);
    wr(A_CMP, 8'h04);
    wr(A_CTRL, 8'h07);
    run = 1'b1;
    nf = 0;
    for (int i = 0; i < 40 && nf == 0; i++) begin
      step();
      if (sampled == 8'h08) begin
        check("sim_ack_fire", fire, 1);
        rd_chk("sim_ack_status", A_STATUS, 8'h01);
        check("sim_ack_irq", irq, 1);
      end
      if (sampled == 8'h0C) begin
        check("sim_cmp_fire", fire, 1);
        rd_chk("sim_cmp_wins", A_CMP, 8'h77);
        nf = 1;
      end
      irq_ack = (timer_val == 8'h08);
      if (timer_val == 8'h0C && nf == 0) begin
        cfg_we = 1'b1; cfg_addr = A_CMP; cfg_wdata = 8'h77;
      end else begin
        cfg_we = 1'b0;
      end
    end
    cfg_we = 1'b0;
    irq_ack = 1'b0;
    check("sim_reached", nf, 1);

    // Stalled counter at CMP, with a pending W1C on the match cycle
    run = 1'b0;
    wr(A_CTRL, 8'h00);
    wr(A_STATUS, 8'h03);
    timer_val = 8'h0F;
    wr(A_CMP, 8'h10);
    wr(A_CTRL, 8'h05);
    timer_val = 8'h10;
    cfg_we = 1'b1; cfg_addr = A_STATUS; cfg_wdata = 8'h01;
    step();
    cfg_we = 1'b0;
    check("stall_fire", fire, 1);
    rd_chk("stall_set_wins", A_STATUS, 8'h01);
    extra = fire ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (fire) extra++;
    end
    check("stall_once", extra, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
